if_stage: RTL and testbench

// Instruction-fetch stage of pipelined_mips: owns the PC, the word-addressed instruction

---
 rtl/if_stage.sv | 80 ++++++++
 tb/tb_if_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, word-addressed instruction ROM and the
// IF/ID pipeline register, with redirect (flush) taking priority over stall.
module if_stage #(
  parameter int          MEM_WORDS = 256,
  parameter int          ADDR_BITS = 8,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] NOP_WORD  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  // Loaded from outside by the bench; there is deliberately no write port.
  logic [31:0] mem_data [MEM_WORDS];

  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          pc4_q, pc4_d;
  logic                 valid_q, valid_d;
  logic [31:0]          count_q, count_d;
  logic [31:0]          pc_plus4;
  logic [31:0]          fetch_word;
  logic [ADDR_BITS-1:0] word_idx;

  assign pc_plus4   = pc_q + 32'd4;
  assign word_idx   = pc_q[ADDR_BITS+1:2];
  assign fetch_word = mem_data[word_idx];

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (redirect) begin
      // Squash the wrong-path fetch; a simultaneous stall is dropped.
      pc_d    = {redirect_pc[31:2], 2'b00};
      instr_d = NOP_WORD;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_plus4;
      instr_d = fetch_word;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, redirect, redirect+stall,
// address wrap and asynchronous mid-cycle reset.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                          input logic [31:0] e_pc4, input logic e_vld, input logic [31:0] e_cnt);
    chk({tag, ".pc"},    pc,                  e_pc);
    chk({tag, ".instr"}, if_id_instr,         e_instr);
    chk({tag, ".pc4"},   if_id_pc4,           e_pc4);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, e_vld});
    chk({tag, ".count"}, fetch_count,         e_cnt);
  endtask

  initial begin
    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    for (int i = 0; i < 256; i++) dut.mem_data[i] = 32'hA000_0000 | 32'(i);
    dut.mem_data[0] = 32'h1111_1111;
    dut.mem_data[1] = 32'h2222_2222;
    dut.mem_data[2] = 32'h3333_3333;
    dut.mem_data[3] = 32'h4444_4444;

    #2;
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    // Sequential fetch
    @(posedge clk);
    #1 reset = 1'b1;
    chk("rel.pc", pc, 32'h0);
    step();
    chk_ifid("seq1", 32'h4, 32'h1111_1111, 32'h4, 1'b1, 32'd1);
    step();
    chk_ifid("seq2", 32'h8, 32'h2222_2222, 32'h8, 1'b1, 32'd2);

    // Stall two cycles at pc=8
    stall = 1'b1;
    step();
    chk_ifid("stall1", 32'h8, 32'h2222_2222, 32'h8, 1'b1, 32'd2);
    step();
    chk_ifid("stall2", 32'h8, 32'h2222_2222, 32'h8, 1'b1, 32'd2);
    stall = 1'b0;
    step();
    chk_ifid("unstall", 32'hC, 32'h3333_3333, 32'hC, 1'b1, 32'd3);
    step();
    chk_ifid("seq4", 32'h10, 32'h4444_4444, 32'h10, 1'b1, 32'd4);

    // Redirect to 5E (low bits dropped -> 5C)
    redirect    = 1'b1;
    redirect_pc = 32'h0000_005E;
    step();
    chk_ifid("redir", 32'h5C, 32'h0, 32'h0, 1'b0, 32'd4);
    redirect = 1'b0;
    step();
    chk_ifid("postredir", 32'h60, 32'hA000_0017, 32'h60, 1'b1, 32'd5);

    // Redirect and stall together
    redirect    = 1'b1;
    stall       = 1'b1;
    redirect_pc = 32'h40;
    step();
    chk_ifid("redir_stall", 32'h40, 32'h0, 32'h0, 1'b0, 32'd5);

    // Back-to-back redirect, then wrap of the memory index
    stall       = 1'b0;
    redirect_pc = 32'h3FC;
    step();
    chk_ifid("redir2", 32'h3FC, 32'h0, 32'h0, 1'b0, 32'd5);
    redirect = 1'b0;
    step();
    chk_ifid("word255", 32'h400, 32'hA000_00FF, 32'h400, 1'b1, 32'd6);
    step();
    chk_ifid("wrap0", 32'h404, 32'h1111_1111, 32'h404, 1'b1, 32'd7);

    // 32-bit PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    chk_ifid("redir_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd7);
    redirect = 1'b0;
    step();
    chk_ifid("pcwrap", 32'h0, 32'hA000_00FF, 32'h0, 1'b1, 32'd8);

    // Mid-cycle async reset at pc=24 with valid IF/ID
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    step();
    chk_ifid("pc24", 32'h24, 32'hA000_0008, 32'h24, 1'b1, 32'd9);
    #3 reset = 1'b0;
    #1;
    chk_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    chk_ifid("after_rst", 32'h4, 32'h1111_1111, 32'h4, 1'b1, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
